// File: rtl/traffic_nway.sv
// traffic_nway: N-approach round-robin traffic-light controller.
// Each approach in turn gets GREEN -> YELLOW -> ALL-RED clearance. Idle
// approaches can be skipped (SKIP_EN) and green can be stretched by up to
// MAX_EXT cycles while ext is held at the end of the green phase.
// lights, cur_way and busy are registers loaded from the next-state logic,
// so every output is glitch-free and changes only on a clock edge or reset.
module traffic_nway #(
    parameter int N_WAYS     = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1,
    parameter int MAX_EXT    = 4,
    parameter int SKIP_EN    = 1,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_WAYS-1:0]     req,
    input  logic                  ext,
    output logic [2*N_WAYS-1:0]   lights,
    output logic [2:0]            cur_way,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] EXT_MAX  = CNT_W'(MAX_EXT);
    localparam logic [2:0]       WAY_LAST = 3'(N_WAYS - 1);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [CNT_W-1:0]      ext_used_r;
    logic [CNT_W-1:0]      ext_used_nxt_s;
    logic [2:0]            way_r;
    logic [2:0]            way_nxt_s;
    logic [2:0]            sel_way_s;
    logic [2*N_WAYS-1:0]   lights_r;
    logic [2*N_WAYS-1:0]   lights_nxt_s;
    logic                  busy_r;
    logic                  busy_nxt_s;

    // Next approach to serve: scan forward from the current one (current one
    // last) for a demanding approach; with no demand, or skipping disabled,
    // simply advance by one so the rotation never stalls.
    function automatic logic [2:0] pick_next_way(input logic [2:0] cur,
                                                 input logic [N_WAYS-1:0] dem);
        logic [2:0] nxt;
        logic       found;
        int         idx;
        nxt   = 3'((int'(cur) + 1) % N_WAYS);
        found = 1'b0;
        if (SKIP_EN != 0) begin
            for (int k = 1; k <= N_WAYS; k++) begin
                idx = (int'(cur) + k) % N_WAYS;
                if (!found && dem[idx]) begin
                    nxt   = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

    // Candidate approach for the next grant, from the current owner and demand.
    always_comb begin
        sel_way_s = pick_next_way(way_r, req);
    end

    // Phase sequencing: counter, extension budget and approach ownership.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r + CNT_ONE;
        ext_used_nxt_s = ext_used_r;
        way_nxt_s      = way_r;
        case (state_r)
            S_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (start) begin
                    state_nxt_s    = S_GREEN;
                    way_nxt_s      = sel_way_s;
                    ext_used_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_GREEN: begin
                // Once the base green has elapsed every cycle is terminal;
                // each held ext buys one more cycle until the budget is spent.
                if (cnt_r >= G_LAST) begin
                    if (ext && (ext_used_r < EXT_MAX)) begin
                        ext_used_nxt_s = ext_used_r + CNT_ONE;
                    end else begin
                        state_nxt_s = S_YELLOW;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end else begin
                    state_nxt_s = S_GREEN;
                end
            end
            S_YELLOW: begin
                if (cnt_r == Y_LAST) begin
                    state_nxt_s = S_ALLRED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_YELLOW;
                end
            end
            S_ALLRED: begin
                if (cnt_r == R_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (start) begin
                        state_nxt_s    = S_GREEN;
                        way_nxt_s      = sel_way_s;
                        ext_used_nxt_s = CNT_ZERO;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_ALLRED;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Lamp pattern for the upcoming state: only the owning approach is lit.
    always_comb begin
        lights_nxt_s = {(2*N_WAYS){1'b0}};
        busy_nxt_s   = (state_nxt_s != S_IDLE);
        for (int i = 0; i < N_WAYS; i++) begin
            if (3'(i) == way_nxt_s) begin
                case (state_nxt_s)
                    S_GREEN:  lights_nxt_s[2*i +: 2] = 2'b01;
                    S_YELLOW: lights_nxt_s[2*i +: 2] = 2'b10;
                    default:  lights_nxt_s[2*i +: 2] = 2'b00;
                endcase
            end else begin
                lights_nxt_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // State and output registers; reset forces all-red IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            ext_used_r <= CNT_ZERO;
            way_r      <= WAY_LAST;
            lights_r   <= {(2*N_WAYS){1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ext_used_r <= ext_used_nxt_s;
            way_r      <= way_nxt_s;
            lights_r   <= lights_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign lights  = lights_r;
    assign cur_way = way_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_traffic_nway.sv
// Testbench for traffic_nway: a timeline model (time since grant, green length)
// predicts lights/cur_way/busy every cycle under directed and random stimulus.
module tb_traffic_nway;

    localparam int N    = 4;
    localparam int GC   = 8;
    localparam int YC   = 3;
    localparam int RC   = 1;
    localparam int MX   = 4;
    localparam int SKIP = 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   req;
    logic           ext;
    logic [2*N-1:0] lights;
    logic [2:0]     cur_way;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    // Model: idle flag, owning way, cycles since grant, current green length.
    bit m_idle;
    int m_way;
    int m_t;
    int m_glen;

    traffic_nway #(
        .N_WAYS(N), .GREEN_CYC(GC), .YELLOW_CYC(YC), .ALLRED_CYC(RC),
        .MAX_EXT(MX), .SKIP_EN(SKIP), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .ext(ext),
        .lights(lights), .cur_way(cur_way), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_way(input int cur, input logic [N-1:0] r);
        if (SKIP != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (r[(cur + k) % N]) return (cur + k) % N;
            end
        end
        return (cur + 1) % N;
    endfunction

    function automatic logic [2*N-1:0] exp_lights();
        logic [2*N-1:0] v;
        v = '0;
        if (!m_idle) begin
            if (m_t < m_glen) v[2*m_way +: 2] = 2'b01;
            else if (m_t < m_glen + YC) v[2*m_way +: 2] = 2'b10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_way = N - 1; m_t = 0; m_glen = GC;
    endtask

    task automatic model_step(input logic s, input logic [N-1:0] r, input logic e);
        if (m_idle) begin
            if (s) begin
                m_way = next_way(m_way, r); m_idle = 1'b0; m_t = 0; m_glen = GC;
            end
        end else if (m_t == m_glen + YC + RC - 1) begin
            if (s) begin
                m_way = next_way(m_way, r); m_t = 0; m_glen = GC;
            end else begin
                m_idle = 1'b1; m_t = 0;
            end
        end else begin
            if (m_t == m_glen - 1 && e && m_glen < GC + MX) m_glen++;
            m_t++;
        end
    endtask

    // Apply inputs for one clock, advance model, sample just after the edge.
    task automatic tick(input logic s, input logic [N-1:0] r, input logic e);
        start = s; req = r; ext = e;
        model_step(s, r, e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_idle();
        for (int i = 0; i < 40 && !m_idle; i++) tick(1'b0, '0, 1'b0);
        checks++;
        if (!m_idle || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle busy=%b required=0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; req = '0; ext = 1'b0;
        model_reset();
        #12;
        checks++;
        if (lights !== '0) begin failures++; $display("FAIL reset_lights got=%b exp=0", lights); end
        checks++;
        if (cur_way !== 3'(N - 1)) begin failures++; $display("FAIL reset_way got=%0d exp=%0d", cur_way, N - 1); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        for (int c = 0; c < 2 * 12 * N + 6; c++) begin
            tick(1'b1, '0, 1'b0);
            checks++;
            if (lights !== exp_lights() || cur_way !== 3'(m_way) || busy !== !m_idle) begin
                failures++;
                $display("FAIL rotation c=%0d lights=%b exp=%b way=%0d exp=%0d busy=%b",
                         c, lights, exp_lights(), cur_way, m_way, busy);
            end
        end
        drain_idle();
    endtask

    task automatic test_skip();
        int bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick(1'b1, 4'b1010, 1'b0);
            checks++;
            if (lights !== exp_lights() || cur_way !== 3'(m_way) || busy !== !m_idle) begin
                failures++;
                $display("FAIL skip c=%0d lights=%b exp=%b way=%0d exp=%0d",
                         c, lights, exp_lights(), cur_way, m_way);
            end
            if (lights[1:0] !== 2'b00 || lights[5:4] !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL skip_idle_ways lit_cycles=%0d exp=0", bad); end
        drain_idle();
    endtask

    task automatic test_extension();
        int w;
        int g;
        bit used;
        // ext held through the whole green: 8 base + 4 extension cycles.
        tick(1'b1, '0, 1'b0);
        w = m_way; g = 0;
        for (int c = 0; c < 30 && lights[2*w +: 2] === 2'b01; c++) begin
            g++;
            checks++;
            if (lights !== exp_lights() || cur_way !== 3'(m_way)) begin
                failures++;
                $display("FAIL ext_hold c=%0d lights=%b exp=%b", c, lights, exp_lights());
            end
            tick(1'b0, '0, 1'b1);
        end
        checks++;
        if (g != GC + MX) begin failures++; $display("FAIL ext_hold_len got=%0d exp=%0d", g, GC + MX); end
        drain_idle();
        // ext pulsed once on the terminal green cycle: one extra cycle.
        tick(1'b1, '0, 1'b0);
        w = m_way; g = 0; used = 1'b0;
        for (int c = 0; c < 30 && lights[2*w +: 2] === 2'b01; c++) begin
            g++;
            checks++;
            if (lights !== exp_lights()) begin
                failures++;
                $display("FAIL ext_once c=%0d lights=%b exp=%b", c, lights, exp_lights());
            end
            if (g == GC && !used) begin
                used = 1'b1;
                tick(1'b0, '0, 1'b1);
            end else begin
                tick(1'b0, '0, 1'b0);
            end
        end
        checks++;
        if (g != GC + 1) begin failures++; $display("FAIL ext_once_len got=%0d exp=%0d", g, GC + 1); end
        drain_idle();
    endtask

    task automatic test_stop();
        tick(1'b1, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            tick(1'b0, '0, 1'b0);
            checks++;
            if (lights !== exp_lights() || busy !== !m_idle) begin
                failures++;
                $display("FAIL stop c=%0d lights=%b exp=%b busy=%b", c, lights, exp_lights(), busy);
            end
        end
        checks++;
        if (busy !== 1'b0 || lights !== '0) begin
            failures++;
            $display("FAIL stop_idle busy=%b lights=%b exp busy=0 lights=0", busy, lights);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, '0, 1'b0);
        for (int c = 0; c < 20 && m_t < m_glen + 1; c++) tick(1'b1, '0, 1'b0);
        checks++;
        if (lights === '0) begin failures++; $display("FAIL areset_pre lights=%b exp=nonzero", lights); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (lights !== '0 || busy !== 1'b0 || cur_way !== 3'(N - 1)) begin
            failures++;
            $display("FAIL areset_now lights=%b busy=%b way=%0d exp 0/0/%0d", lights, busy, cur_way, N - 1);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, '0, 1'b0);
        checks++;
        if (cur_way !== 3'd0 || lights[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL areset_restart way=%0d lights=%b exp way0 green", cur_way, lights);
        end
    endtask

    task automatic test_random();
        int lit;
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 9) != 0), N'($urandom), 1'($urandom));
            lit = 0;
            for (int i = 0; i < N; i++) begin
                if (lights[2*i +: 2] !== 2'b00) lit++;
                if (lights[2*i +: 2] === 2'b11) lit += 10;
            end
            checks++;
            if (lights !== exp_lights() || cur_way !== 3'(m_way) || busy !== !m_idle || lit > 1) begin
                failures++;
                $display("FAIL random c=%0d lights=%b exp=%b way=%0d exp=%0d busy=%b lit=%0d",
                         c, lights, exp_lights(), cur_way, m_way, busy, lit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_skip();
        test_extension();
        test_stop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
